sync_tx_arbiter: RTL and testbench

Source-domain controller that shares one multi-bit data-synchronizer crossing among NUM_REQ requesters. It arbitrates round-robin, captures the winner's byte, and drives the synchronizer's unsynchronized bus and bus-enable. It holds the enable for HOLD_CYCLES and keeps the bus stable through a further GAP_CYCLES guard interval so the destination can sample cleanly. It sits between the source-domain producers (UART RX path, register file, ALU result) and the data synchronizer's source-side inputs.

---
 rtl/sync_tx_arbiter.sv | 104 ++++++++++
 tb/tb_sync_tx_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_tx_arbiter.sv
// Round-robin front end for a shared multi-bit CDC synchronizer: picks one requester,
// drives its byte onto the unsynchronized bus and frames it with enable + guard time.
module sync_tx_arbiter #(
  parameter int BUS_WIDTH   = 8,
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           Arb_En,
  input  logic [NUM_REQ-1:0]             Req,
  input  logic [NUM_REQ*BUS_WIDTH-1:0]   Req_Data,
  output logic [NUM_REQ-1:0]             Grant,
  output logic [BUS_WIDTH-1:0]           Unsync_Bus,
  output logic                           Bus_Enable,
  output logic                           Busy,
  output logic [$clog2(NUM_REQ)-1:0]     Grant_Id
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int MAXC  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW    = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t                             state;
  logic [CW-1:0]                      cnt;
  logic [ID_W-1:0]                    ptr;
  logic [ID_W-1:0]                    win;
  logic [ID_W-1:0]                    idx;
  logic                               found;
  logic [NUM_REQ-1:0][BUS_WIDTH-1:0]  req_words;

  assign req_words = Req_Data;

  // Search starts one past the last winner so every pending requester gets a turn.
  always_comb begin
    win   = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && Req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= ID_W'(NUM_REQ - 1);
      Grant      <= '0;
      Unsync_Bus <= '0;
      Bus_Enable <= 1'b0;
      Busy       <= 1'b0;
      Grant_Id   <= '0;
    end else begin
      Grant <= '0;
      case (state)
        IDLE: begin
          if (Arb_En && found) begin
            Unsync_Bus <= req_words[win];
            Bus_Enable <= 1'b1;
            Busy       <= 1'b1;
            Grant      <= NUM_REQ'(1) << win;
            Grant_Id   <= win;
            ptr        <= win;
            cnt        <= HOLD_LOAD;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            Bus_Enable <= 1'b0;
            if (GAP_CYCLES > 0) begin
              cnt   <= GAP_LOAD;
              state <= GAP;
            end else begin
              Busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          // Bus stays put here so the destination's late sample still sees stable data.
          if (cnt == '0) begin
            Busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sync_tx_arbiter.sv
// Directed bench for sync_tx_arbiter at default parameters (4 requesters, hold 4, gap 2).
module tb_sync_tx_arbiter;
  logic        CLK = 1'b0;
  logic        RST;
  logic        Arb_En;
  logic [3:0]  Req;
  logic [31:0] Req_Data;
  logic [3:0]  Grant;
  logic [7:0]  Unsync_Bus;
  logic        Bus_Enable;
  logic        Busy;
  logic [1:0]  Grant_Id;

  int vectors    = 0;
  int miscompares = 0;

  sync_tx_arbiter #(.BUS_WIDTH(8), .NUM_REQ(4), .HOLD_CYCLES(4), .GAP_CYCLES(2)) dut (
    .CLK(CLK), .RST(RST), .Arb_En(Arb_En), .Req(Req), .Req_Data(Req_Data),
    .Grant(Grant), .Unsync_Bus(Unsync_Bus), .Bus_Enable(Bus_Enable),
    .Busy(Busy), .Grant_Id(Grant_Id)
  );

  always #5 CLK = ~CLK;

  // Outputs are sampled and inputs changed on the falling edge.
  task automatic tick;
    @(negedge CLK);
  endtask

  task automatic test_reset;
    RST = 1'b1; Arb_En = 1'b1; Req = 4'b1111; Req_Data = 32'h3C5A92AC;
    for (int i = 0; i < 2; i++) begin
      tick;
      vectors++;
      if ({Grant, Bus_Enable, Busy, Unsync_Bus, Grant_Id} !== 16'h0000) begin
        miscompares++;
        $display("FAIL reset_outputs: got %h expected 0000",
                 {Grant, Bus_Enable, Busy, Unsync_Bus, Grant_Id});
      end
    end
  endtask

  task automatic test_single;
    RST = 1'b0; Req = 4'b0001; Req_Data = 32'h000000BE;
    tick;
    vectors++;
    if ({Grant, Bus_Enable, Busy, Unsync_Bus, Grant_Id} !== {4'b0001, 1'b1, 1'b1, 8'hBE, 2'd0}) begin
      miscompares++;
      $display("FAIL single_grant: got %b expected %b",
               {Grant, Bus_Enable, Busy, Unsync_Bus, Grant_Id}, {4'b0001, 1'b1, 1'b1, 8'hBE, 2'd0});
    end
    Req = 4'b0000;
    for (int i = 1; i <= 6; i++) begin
      tick;
      vectors++;
      if ({Grant, Bus_Enable, Busy, Unsync_Bus} !== {4'b0000, (i <= 3), (i <= 5), 8'hBE}) begin
        miscompares++;
        $display("FAIL single_frame cyc%0d: got %b expected %b", i + 1,
                 {Grant, Bus_Enable, Busy, Unsync_Bus}, {4'b0000, (i <= 3), (i <= 5), 8'hBE});
      end
    end
    tick;
    vectors++;
    if ({Grant, Bus_Enable, Busy, Unsync_Bus} !== {4'b0000, 1'b0, 1'b0, 8'hBE}) begin
      miscompares++;
      $display("FAIL single_idle_hold: got %b expected %b",
               {Grant, Bus_Enable, Busy, Unsync_Bus}, {4'b0000, 1'b0, 1'b0, 8'hBE});
    end
  endtask

  task automatic test_round_robin;
    logic [7:0] d;
    RST = 1'b1;
    tick;
    RST = 1'b0; Req = 4'b1111; Req_Data = 32'h3C5A92AC;
    for (int k = 0; k < 4; k++) begin
      d = Req_Data[k*8 +: 8];
      tick;
      vectors++;
      if ({Grant, Bus_Enable, Busy, Unsync_Bus, Grant_Id} !== {4'(1 << k), 1'b1, 1'b1, d, 2'(k)}) begin
        miscompares++;
        $display("FAIL rr_grant%0d: got %b expected %b", k,
                 {Grant, Bus_Enable, Busy, Unsync_Bus, Grant_Id}, {4'(1 << k), 1'b1, 1'b1, d, 2'(k)});
      end
      for (int i = 1; i <= 6; i++) begin
        tick;
        vectors++;
        if ({Grant, Bus_Enable, Busy, Unsync_Bus} !== {4'b0000, (i <= 3), (i <= 5), d}) begin
          miscompares++;
          $display("FAIL rr_frame%0d cyc%0d: got %b expected %b", k, i + 1,
                   {Grant, Bus_Enable, Busy, Unsync_Bus}, {4'b0000, (i <= 3), (i <= 5), d});
        end
      end
    end
  endtask

  task automatic test_alternate;
    int ids[4] = '{0, 2, 0, 2};
    int id;
    logic [7:0] d;
    Req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      id = ids[k];
      d  = Req_Data[id*8 +: 8];
      tick;
      vectors++;
      if ({Grant, Bus_Enable, Unsync_Bus, Grant_Id} !== {4'(1 << id), 1'b1, d, 2'(id)}) begin
        miscompares++;
        $display("FAIL alt_grant%0d: got %b expected %b", k,
                 {Grant, Bus_Enable, Unsync_Bus, Grant_Id}, {4'(1 << id), 1'b1, d, 2'(id)});
      end
      for (int i = 1; i <= 6; i++) begin
        tick;
        vectors++;
        if ({Grant, Bus_Enable, Unsync_Bus} !== {4'b0000, (i <= 3), d}) begin
          miscompares++;
          $display("FAIL alt_frame%0d cyc%0d: got %b expected %b", k, i + 1,
                   {Grant, Bus_Enable, Unsync_Bus}, {4'b0000, (i <= 3), d});
        end
      end
    end
    Req = 4'b0000;
  endtask

  task automatic test_arb_en;
    Arb_En = 1'b0; Req = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      tick;
      vectors++;
      if ({Grant, Bus_Enable, Busy, Unsync_Bus} !== {4'b0000, 1'b0, 1'b0, 8'h5A}) begin
        miscompares++;
        $display("FAIL arb_off_idle cyc%0d: got %b expected %b", i,
                 {Grant, Bus_Enable, Busy, Unsync_Bus}, {4'b0000, 1'b0, 1'b0, 8'h5A});
      end
    end
    Arb_En = 1'b1;
    tick;
    vectors++;
    if ({Grant, Bus_Enable, Unsync_Bus, Grant_Id} !== {4'b0010, 1'b1, 8'h92, 2'd1}) begin
      miscompares++;
      $display("FAIL arb_on_grant: got %b expected %b",
               {Grant, Bus_Enable, Unsync_Bus, Grant_Id}, {4'b0010, 1'b1, 8'h92, 2'd1});
    end
    Arb_En = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick;
      vectors++;
      if ({Grant, Bus_Enable, Busy, Unsync_Bus} !== {4'b0000, (i <= 3), (i <= 5), 8'h92}) begin
        miscompares++;
        $display("FAIL arb_drop_frame cyc%0d: got %b expected %b", i + 1,
                 {Grant, Bus_Enable, Busy, Unsync_Bus}, {4'b0000, (i <= 3), (i <= 5), 8'h92});
      end
    end
    Req = 4'b0000;
  endtask

  task automatic test_reset_mid;
    Arb_En = 1'b1; Req = 4'b0010;
    tick;
    vectors++;
    if ({Grant, Bus_Enable, Unsync_Bus} !== {4'b0010, 1'b1, 8'h92}) begin
      miscompares++;
      $display("FAIL mid_grant: got %b expected %b",
               {Grant, Bus_Enable, Unsync_Bus}, {4'b0010, 1'b1, 8'h92});
    end
    Req = 4'b0001;
    tick;
    vectors++;
    if ({Grant, Bus_Enable, Busy} !== {4'b0000, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL mid_hold2: got %b expected %b", {Grant, Bus_Enable, Busy}, {4'b0000, 1'b1, 1'b1});
    end
    RST = 1'b1;
    tick;
    vectors++;
    if ({Grant, Bus_Enable, Busy, Unsync_Bus, Grant_Id} !== 16'h0000) begin
      miscompares++;
      $display("FAIL mid_reset: got %h expected 0000", {Grant, Bus_Enable, Busy, Unsync_Bus, Grant_Id});
    end
    RST = 1'b0;
    tick;
    vectors++;
    if ({Grant, Bus_Enable, Busy, Unsync_Bus, Grant_Id} !== {4'b0001, 1'b1, 1'b1, 8'hAC, 2'd0}) begin
      miscompares++;
      $display("FAIL post_reset_grant: got %b expected %b",
               {Grant, Bus_Enable, Busy, Unsync_Bus, Grant_Id}, {4'b0001, 1'b1, 1'b1, 8'hAC, 2'd0});
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_alternate;
    test_arb_en;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
